// File: rtl/alu_op_sequencer.sv
// Shares one external ALU between two requesters: round-robin arbitration, holds
// operands for the op latency, returns the result tagged with the requester id.
// Build option FIXED_PRIO_EN: requester 0 always wins ties (no round-robin state).
module alu_op_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 34,
  parameter int unsigned ALU_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_res,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy
);

  localparam logic [2:0] OP_MULT   = 3'b011;
  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] ALU_LOAD  = 8'(ALU_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             id_q,    id_d;
  logic [WIDTH-1:0] res_q,   res_d;
`ifndef FIXED_PRIO_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic grant0;
  logic grant1;

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !reset) begin
`ifdef FIXED_PRIO_EN
      if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    res_d   = res_q;
`ifndef FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          id_d    = grant1;
          cnt_d   = (op_d == OP_MULT) ? MULT_LOAD : ALU_LOAD;
          state_d = S_EXEC;
`ifndef FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
        end
      end
      S_EXEC: begin
        if (cnt_q == 8'd0) begin
          res_d   = alu_res;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
`ifndef FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
`ifndef FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_res   = res_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked every cycle against a transaction-level model.
module tb_alu_op_sequencer;

  localparam int MC = 34;
  localparam int AC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_id, busy;
  logic [31:0] resp_res, alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .MULT_CYCLES(MC), .ALU_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_res(resp_res), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .busy(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'b000: return a + b;
      3'b001: return a ^ b;
      3'b010: return a - b;
      3'b011: return 32'(a * b);
      3'b100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: return ~(a | b);
      3'b110: return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_op, alu_a, alu_b);

  // Transaction-level model: an op in flight, cycles left until its result shows.
  bit          m_active = 0, m_resp = 0, m_id = 0, m_lastg = 1;
  int          m_left = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;

  logic        s_r0, s_r1, s_rv, s_id, s_busy;
  logic [31:0] s_res, s_a, s_b;
  logic [2:0]  s_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    int win;
    @(negedge clk);
    cyc++;
    s_r0 = req0_ready; s_r1 = req1_ready; s_rv = resp_valid; s_id = resp_id;
    s_res = resp_res; s_a = alu_a; s_b = alu_b; s_op = alu_op; s_busy = busy;
    win = -1;
    if (!m_active && !reset) begin
`ifdef FIXED_PRIO_EN
      if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
`else
      if (req0_valid && req1_valid) win = m_lastg ? 0 : 1;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
`endif
    end
    chk("req0_ready", 32'(s_r0), 32'(win == 0));
    chk("req1_ready", 32'(s_r1), 32'(win == 1));
    if (!reset) begin
      chk("busy", 32'(s_busy), 32'(m_active));
      chk("resp_valid", 32'(s_rv), 32'(m_resp));
      chk("alu_op", 32'(s_op), 32'(m_op));
      chk("alu_a", s_a, m_a);
      chk("alu_b", s_b, m_b);
      if (m_resp) begin
        chk("resp_id", 32'(s_id), 32'(m_id));
        chk("resp_res", s_res, m_res);
      end
    end
    if (reset) begin
      m_active = 0; m_resp = 0; m_id = 0; m_lastg = 1; m_left = 0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    end else if (!m_active) begin
      if (win >= 0) begin
        m_active = 1; m_resp = 0; m_id = (win == 1); m_lastg = (win == 1);
        m_op = m_id ? req1_op : req0_op;
        m_a  = m_id ? req1_a : req0_a;
        m_b  = m_id ? req1_b : req0_b;
        m_left = (m_op == 3'b011) ? MC : AC;
      end
    end else if (!m_resp) begin
      m_left--;
      if (m_left == 0) begin
        m_resp = 1;
        m_res = alu_fn(m_op, m_a, m_b);
      end
    end else if (resp_ready) begin
      m_active = 0; m_resp = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int who);
    who = -1;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (s_r0 || s_r1) begin
        who = s_r1 ? 1 : 0;
        acc_cyc = cyc;
        break;
      end
    end
    if (who < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(input logic [31:0] ea, input logic [31:0] eb, output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      cycle();
      if (s_rv) begin
        lat = cyc - acc_cyc;
        break;
      end
      chk("hold_a", s_a, ea);
      chk("hold_b", s_b, eb);
    end
    if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input bit id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int who, lat, h, seen;
    vecs[0] = '{0, 3'b011, 32'd15, 32'd3, 32'd45, MC + 1};
    vecs[1] = '{1, 3'b000, 32'd13, 32'd12, 32'd25, AC + 1};
    vecs[2] = '{0, 3'b100, 32'h0200000D, 32'h2200000C, 32'd1, AC + 1};
    vecs[3] = '{0, 3'b101, 32'h0200000D, 32'h0200000C, 32'hFDFFFFF2, AC + 1};
    vecs[4] = '{1, 3'b111, 32'h0200000D, 32'h0200000C, 32'h0200000D, AC + 1};
    vecs[5] = '{1, 3'b010, 32'd13, 32'd7, 32'd6, AC + 1};
    vecs[6] = '{0, 3'b010, 32'd7, 32'd13, 32'hFFFFFFFA, AC + 1};

    cycle();
    do_reset();
    cycle();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_resp_valid", 32'(s_rv), 32'd0);
    chk("rst_resp_res", s_res, 32'd0);
    chk("rst_alu_a", s_a, 32'd0);

    // Directed single-op vectors with resp_ready held high.
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_accept(who);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("vec_grant", 32'(who), 32'(vecs[i].id));
      wait_resp(vecs[i].a, vecs[i].b, lat);
      chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
      chk("vec_res", s_res, vecs[i].res);
      chk("vec_id", 32'(s_id), 32'(vecs[i].id));
    end

    // Both requesters valid continuously: grants alternate (or stay 0 with fixed priority).
    do_reset();
    set_req(0, 3'b010, 32'd13, 32'd7);
    set_req(1, 3'b010, 32'd7, 32'd13);
    for (int k = 0; k < 4; k++) begin
      wait_accept(who);
`ifdef FIXED_PRIO_EN
      chk("rr_grant", 32'(who), 32'd0);
`else
      chk("rr_grant", 32'(who), 32'(k % 2));
`endif
      wait_resp(who == 1 ? 32'd7 : 32'd13, who == 1 ? 32'd13 : 32'd7, lat);
      chk("rr_id", 32'(s_id), 32'(who));
      chk("rr_res", s_res, who == 1 ? 32'hFFFFFFFA : 32'd6);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();

    // Response back-pressure: result and id stay put, no grants while RESP.
    resp_ready = 1'b0;
    set_req(0, 3'b100, 32'h0200000D, 32'h2200000C);
    wait_accept(who);
    req0_valid = 1'b0;
    set_req(1, 3'b000, 32'd1, 32'd2);
    wait_resp(32'h0200000D, 32'h2200000C, lat);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_valid", 32'(s_rv), 32'd1);
      chk("bp_res", s_res, 32'd1);
      chk("bp_id", 32'(s_id), 32'd0);
      chk("bp_ready", 32'({s_r0, s_r1}), 32'd0);
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    cycle();
    cycle();
    chk("bp_idle", 32'(s_busy), 32'd0);

    // Reset in the middle of a mult aborts it without a response.
    set_req(0, 3'b011, 32'd15, 32'd3);
    wait_accept(who);
    req0_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    do_reset();
    cycle();
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_valid", 32'(s_rv), 32'd0);
    chk("abort_alu", {s_op == 3'd0, s_a == 32'd0, s_b == 32'd0}, 32'd7);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (s_rv) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    set_req(0, 3'b000, 32'd13, 32'd12);
    wait_accept(who);
    req0_valid = 1'b0;
    wait_resp(32'd13, 32'd12, lat);
    chk("abort_add_res", s_res, 32'd25);

    // Back-to-back from one requester: second accept one cycle after the handshake.
    set_req(0, 3'b101, 32'h0200000D, 32'h0200000C);
    wait_accept(who);
    req0_op = 3'b111;
    wait_resp(32'h0200000D, 32'h0200000C, lat);
    chk("b2b_res0", s_res, 32'hFDFFFFF2);
    h = cyc;
    wait_accept(who);
    chk("b2b_gap", 32'(acc_cyc - h), 32'd1);
    req0_valid = 1'b0;
    wait_resp(32'h0200000D, 32'h0200000C, lat);
    chk("b2b_res1", s_res, 32'h0200000D);

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 4000; k++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
